// File: rtl/ic_bus_bram_bridge_q.sv
// ic_bus_bram_bridge_q
// Bridges a req/gnt + recv/ack memory bus onto a single-cycle-latency BRAM port.
// Requests are forwarded to the BRAM combinationally on acceptance. Responses are
// queued in order in a small FIFO.
//
// Handshakes:
//   request  : transfer on mem_req && mem_gnt.
//              The master holds mem_* stable until it sees the grant.
//   response : transfer on mem_recv && mem_ack.
//              The head (mem_rdata/mem_error) stays stable while mem_ack is low.
//
// Ports:
//   g_clk, g_resetn        clock, asynchronous active-low reset
//   enable                 bridge enable; while low every request returns an error
//   mem_req/gnt/wen/strb/wdata/addr   request channel
//   mem_recv/ack/error/rdata          response channel
//   bram_cen/addr/wdata/wstrb         BRAM command (combinational from request)
//   bram_stall, bram_rdata            BRAM stall and read data (1-cycle latency)
//
// Optional feature: define IC_BUS_BRAM_BRIDGE_BYPASS_EN to present the in-flight
// response directly when the FIFO is empty. This gives 1-cycle response latency
// instead of 2.
module ic_bus_bram_bridge_q #(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             RSP_DEPTH = 2,
    parameter logic [AW-1:0]  WIN_BASE  = '0,
    parameter logic [AW-1:0]  WIN_MASK  = {AW{1'b1}} << 16
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              enable,
    input  logic              mem_req,
    output logic              mem_gnt,
    input  logic              mem_wen,
    input  logic [DW/8-1:0]   mem_strb,
    input  logic [DW-1:0]     mem_wdata,
    input  logic [AW-1:0]     mem_addr,
    output logic              mem_recv,
    input  logic              mem_ack,
    output logic              mem_error,
    output logic [DW-1:0]     mem_rdata,
    output logic              bram_cen,
    output logic [AW-1:0]     bram_addr,
    output logic [DW-1:0]     bram_wdata,
    output logic [DW/8-1:0]   bram_wstrb,
    input  logic              bram_stall,
    input  logic [DW-1:0]     bram_rdata
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          infl_valid_q, infl_valid_d;
    logic          infl_err_q, infl_err_d;
    logic          infl_wen_q, infl_wen_d;
    logic [DW-1:0] fifo_data_q [RSP_DEPTH];
    logic [DW-1:0] fifo_data_d [RSP_DEPTH];
    logic          fifo_err_q  [RSP_DEPTH];
    logic          fifo_err_d  [RSP_DEPTH];

    logic          in_window;
    logic [CW-1:0] outstanding;
    logic          accept;
    logic          fifo_empty;
    logic [DW-1:0] rsp_data;
    logic          bypass_vld;
    logic          bypass_take;
    logic          push;
    logic          pop;

    always_comb begin
        in_window   = (mem_addr & WIN_MASK) == WIN_BASE;
        // The in-flight slot counts as a credit, so a response always has room in the
        // FIFO. A pop in the same cycle deliberately does not free a credit. This keeps
        // mem_gnt independent of mem_ack.
        outstanding = count_q + CW'(infl_valid_q);
        mem_gnt     = !bram_stall && (outstanding < DEPTH_C);
        accept      = mem_req && mem_gnt;
        bram_cen    = accept && enable && in_window && g_resetn;
        bram_addr   = mem_addr;
        bram_wdata  = mem_wdata;
        bram_wstrb  = mem_wen ? mem_strb : '0;

        // Errors and writes return zero data rather than whatever the BRAM drives.
        rsp_data    = (infl_err_q || infl_wen_q) ? '0 : bram_rdata;
        fifo_empty  = (count_q == '0);
`ifdef IC_BUS_BRAM_BRIDGE_BYPASS_EN
        bypass_vld  = fifo_empty && infl_valid_q;
`else
        bypass_vld  = 1'b0;
`endif
        bypass_take = bypass_vld && mem_ack;
        push        = infl_valid_q && !bypass_take;
        pop         = !fifo_empty && mem_ack;

        mem_recv    = !fifo_empty || bypass_vld;
        mem_rdata   = '0;
        mem_error   = 1'b0;
        if (!fifo_empty) begin
            mem_rdata = fifo_data_q[rd_ptr_q];
            mem_error = fifo_err_q[rd_ptr_q];
        end else if (bypass_vld) begin
            mem_rdata = rsp_data;
            mem_error = infl_err_q;
        end

        infl_valid_d = accept;
        infl_err_d   = !enable || !in_window;
        infl_wen_d   = mem_wen;

        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = rsp_data;
            fifo_err_d[wr_ptr_q]  = infl_err_q;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            infl_valid_q <= 1'b0;
            infl_err_q   <= 1'b0;
            infl_wen_q   <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            infl_valid_q <= infl_valid_d;
            infl_err_q   <= infl_err_d;
            infl_wen_q   <= infl_wen_d;
            fifo_data_q  <= fifo_data_d;
            fifo_err_q   <= fifo_err_d;
        end
    end

endmodule
